// File: rtl/l2_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate L2 cache controller with 256-bit lines.
// Sequences 1-cycle-latency tag/valid/dirty/data arrays through lookup, writeback, fill and re-lookup.
module l2_cache_ctrl #(
    parameter int S_INDEX  = 3,
    parameter int S_OFFSET = 5,
    parameter int S_TAG    = 32 - S_OFFSET - S_INDEX
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_mem_read,
    input  logic         i_mem_write,
    input  logic [31:0]  i_mem_address,
    input  logic [255:0] i_mem_wdata,
    input  logic [31:0]  i_mem_byte_enable,
    output logic [255:0] o_mem_rdata,
    output logic         o_mem_resp,
    output logic         o_pmem_read,
    output logic         o_pmem_write,
    output logic [31:0]  o_pmem_address,
    output logic [255:0] o_pmem_wdata,
    input  logic [255:0] i_pmem_rdata,
    input  logic         i_pmem_resp
);
    localparam int LINES = 1 << S_INDEX;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITEBACK,
        ST_FILL,
        ST_REREAD
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [S_TAG-1:0]   r_tag;
    logic [S_INDEX-1:0] r_index;
    logic [255:0]       r_wdata;
    logic [31:0]        r_be;
    logic               r_is_write;

    logic [255:0]       r_data_arr [LINES];
    logic [S_TAG-1:0]   r_tag_arr  [LINES];
    logic [LINES-1:0]   r_valid;
    logic [LINES-1:0]   r_dirty;

    logic [255:0]       r_rd_data;
    logic [S_TAG-1:0]   r_rd_tag;
    logic               r_rd_valid;
    logic               r_rd_dirty;

    logic               w_req;
    logic [S_INDEX-1:0] w_req_index;
    logic [S_TAG-1:0]   w_req_tag;
    logic               w_rd_en;
    logic [S_INDEX-1:0] w_rd_index;
    logic               w_hit;
    logic               w_wr_hit;
    logic               w_fill_done;
    logic [255:0]       w_merged;
    logic               w_unused_offset;

    assign w_req           = i_mem_read | i_mem_write;
    assign w_req_index     = i_mem_address[S_OFFSET +: S_INDEX];
    assign w_req_tag       = i_mem_address[31 -: S_TAG];
    assign w_unused_offset = ^i_mem_address[S_OFFSET-1:0];

    assign w_rd_en     = ((r_state == ST_IDLE) && w_req) || (r_state == ST_REREAD);
    assign w_rd_index  = (r_state == ST_IDLE) ? w_req_index : r_index;
    assign w_hit       = r_rd_valid && (r_rd_tag == r_tag);
    assign w_wr_hit    = (r_state == ST_LOOKUP) && w_hit && r_is_write;
    assign w_fill_done = (r_state == ST_FILL) && i_pmem_resp;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (w_req) w_next = ST_LOOKUP;
            ST_LOOKUP: begin
                if (w_hit)                         w_next = ST_IDLE;
                else if (r_rd_valid && r_rd_dirty) w_next = ST_WRITEBACK;
                else                               w_next = ST_FILL;
            end
            ST_WRITEBACK: if (i_pmem_resp) w_next = ST_FILL;
            ST_FILL:      if (i_pmem_resp) w_next = ST_REREAD;
            ST_REREAD:    w_next = ST_LOOKUP;
            default:      w_next = ST_IDLE;
        endcase
    end

    // Moore outputs: driven only by state, latched request and registered array outputs.
    always_comb begin
        o_mem_resp     = 1'b0;
        o_mem_rdata    = '0;
        o_pmem_read    = 1'b0;
        o_pmem_write   = 1'b0;
        o_pmem_address = '0;
        o_pmem_wdata   = '0;
        case (r_state)
            ST_LOOKUP: begin
                o_mem_resp = w_hit;
                if (w_hit) o_mem_rdata = r_rd_data;
            end
            ST_WRITEBACK: begin
                o_pmem_write   = 1'b1;
                o_pmem_address = {r_rd_tag, r_index, {S_OFFSET{1'b0}}};
                o_pmem_wdata   = r_rd_data;
            end
            ST_FILL: begin
                o_pmem_read    = 1'b1;
                o_pmem_address = {r_tag, r_index, {S_OFFSET{1'b0}}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tag      <= '0;
            r_index    <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_is_write <= 1'b0;
        end else if (r_state == ST_IDLE && w_req) begin
            r_tag      <= w_req_tag;
            r_index    <= w_req_index;
            r_wdata    <= i_mem_wdata;
            r_be       <= i_mem_byte_enable;
            r_is_write <= i_mem_write;
        end
    end

    always_comb begin
        w_merged = r_rd_data;
        for (int i = 0; i < 32; i++) begin
            if (r_be[i]) w_merged[8*i +: 8] = r_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid    <= '0;
            r_dirty    <= '0;
            r_rd_valid <= 1'b0;
            r_rd_dirty <= 1'b0;
        end else begin
            if (w_fill_done) begin
                r_valid[r_index] <= 1'b1;
                r_dirty[r_index] <= 1'b0;
            end else if (w_wr_hit) begin
                r_dirty[r_index] <= 1'b1;
            end
            if (w_rd_en) begin
                r_rd_valid <= r_valid[w_rd_index];
                r_rd_dirty <= r_dirty[w_rd_index];
            end
        end
    end

    // Tag and data contents are deliberately not reset; valid bits gate their use.
    always_ff @(posedge i_clk) begin
        if (w_fill_done) begin
            r_data_arr[r_index] <= i_pmem_rdata;
            r_tag_arr[r_index]  <= r_tag;
        end else if (w_wr_hit) begin
            r_data_arr[r_index] <= w_merged;
        end
        if (w_rd_en) begin
            r_rd_data <= r_data_arr[w_rd_index];
            r_rd_tag  <= r_tag_arr[w_rd_index];
        end
    end

endmodule
